picomips_core: RTL and testbench
================================

# picomips_core

Parametrised successor to the fixed 8-bit picoMips. It is an accumulator processor that fetches 8-bit instructions from an external synchronous program memory and runs them on a DATA_W-bit signed accumulator and an NREGS-entry register file. Switch polling is replaced by valid/ready input and output streams. It adds jumps, configurable fixed-point scaling and optional saturating arithmetic, and sits between a program ROM and the board I/O (switches/LEDs) or a streaming datapath.

## Interface
- DATA_W, 8: accumulator, register and stream width (≥ 6).
- NREGS, 2: register file entries (power of two, 2..32).
- PC_W, 5: program counter width; program depth 2**PC_W.
- FRAC_W, 3: fractional bits of MULI immediate.
- SAT, 0: 1 means ADD/ADDI/MULI saturate; 0 means they wrap.
- Clock  in  1  single clock, all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- instr_addr  out  PC_W  program memory address, registered.
- instr_data  in  8  program word; valid one cycle after instr_addr changes (synchronous ROM).
- in_data  in  DATA_W  input stream data.
- in_valid  in  1  input stream valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- out_data  out  DATA_W  output stream data, registered.
- out_valid  out  1  output stream valid.
- out_ready  in  1  output consumer ready.
- acc_out  out  DATA_W  live accumulator value (LED drive).

## Operation
- Instruction is {op[7:5], opnd[4:0]}.
- imm = sign_extend(opnd) << 1, taken to DATA_W bits.
- Register address is opnd[log2(NREGS)-1:0].
- Opcodes:
  - 0 JMP: pc <= zero-extend/truncate(opnd) to PC_W.
  - 1 LIN: acc <= in_data, taken on handshake.
  - 2 MULI: acc <= (acc*imm) >>> FRAC_W. Full 2*DATA_W signed product, arithmetic shift, then wrap/saturate.
  - 3 ATR: reg[a] <= acc.
  - 4 RTA: acc <= reg[a].
  - 5 ADD: acc <= acc + reg[a].
  - 6 ADDI: acc <= acc + imm.
  - 7 OUT: out_data <= acc, then handshake.
- Arithmetic: sums are computed at DATA_W+1 bits. With SAT=1, results clamp to [-2**(DATA_W-1), 2**(DATA_W-1)-1]. With SAT=0, the low DATA_W bits are kept.
- FSM states: FETCH, EXEC, OUT_WAIT.
  - FETCH: instr_addr <= pc; next state EXEC.
  - EXEC, ops 2-6: update acc/reg; pc <= pc+1 (mod 2**PC_W); next state FETCH.
  - EXEC, JMP: load pc; next state FETCH.
  - EXEC, LIN: in_ready=1 combinationally. If in_valid, load acc, pc+1, next state FETCH; otherwise stay in EXEC with acc unchanged.
  - EXEC, OUT: out_data <= acc, out_valid <= 1; next state OUT_WAIT.
  - OUT_WAIT: hold out_data/out_valid. On out_ready, set out_valid <= 0, pc+1, next state FETCH.
- in_ready is 0 in every state other than EXEC-with-LIN.
- Reset: pc=0, acc=0, all regs=0, state=FETCH, instr_addr=0, out_data=0, out_valid=0.

## Timing
- ALU ops, JMP, ATR, RTA: 2 cycles each (FETCH+EXEC).
- LIN: 2 cycles plus stall cycles until in_valid.
- OUT: out_valid rises at the end of EXEC. The minimum is 3 cycles when out_ready is already high in the first OUT_WAIT cycle.
- acc_out reflects the new acc the cycle after EXEC.
- An ATR followed by RTA/ADD of the same register sees the written value (2-cycle spacing; no bypass needed).
- out_data must not change while out_valid=1 and out_ready=0.
- Reset asserted mid-stall (EXEC or OUT_WAIT) takes effect immediately. out_valid and in_ready drop to 0 without waiting for a clock.
- pc = 2**PC_W-1 followed by a non-jump instruction wraps to 0.

## Structure
- picomips_pkg holds:
  - op_t enum with the 3-bit opcodes above.
  - state_t enum (FETCH, EXEC, OUT_WAIT).
  - Instruction field position constants.
- Sub-module picomips_alu: combinational, parametrised by DATA_W/FRAC_W/SAT. Inputs op, acc, operand (imm or reg); output result. It contains the saturation logic.
- The core holds the FSM, pc, acc, register file and stream registers.

## Test plan
- DATA_W=8, FRAC_W=3. Program: LIN; MULI 3; OUT; JMP 0. Stream in 40 -> out 30 (0x1E); stream in 40 again -> out 30 again.
- MULI opnd 30 (imm -4, i.e. -0.5) on acc 40 -> out -20 (0xEC). ADDI 10 on acc 0 -> 20.
- acc 100 then ADDI 15 (imm +30): SAT=1 -> 127 (0x7F); SAT=0 -> -126 (0x82). MULI 3 on -128 with SAT=1 -> -96.
- Back-pressure: hold in_valid=0 for 5 cycles at LIN -> in_ready=1, acc and pc unchanged. Hold out_ready=0 for 5 cycles -> out_valid=1, out_data stable, pc unchanged.
- NREGS=4: LIN 7; ATR 3; LIN 5; ADD 3; OUT -> 12. Then RTA 3; OUT -> 7.
- Reset pulse while in OUT_WAIT -> out_valid=0 and instr_addr=0 immediately. First fetch after release is address 0. PC_W=5 program of 32 non-jump instructions wraps to address 0.

Source files
------------

// File: rtl/picomips_pkg.sv
// Shared opcode/state encodings and instruction field positions for the picoMips core.
package picomips_pkg;

    typedef enum logic [2:0] {
        OpJmp  = 3'd0,
        OpLin  = 3'd1,
        OpMuli = 3'd2,
        OpAtr  = 3'd3,
        OpRta  = 3'd4,
        OpAdd  = 3'd5,
        OpAddi = 3'd6,
        OpOut  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        StFetch,
        StExec,
        StOutWait
    } state_t;

    localparam int unsigned OpMsb   = 7;
    localparam int unsigned OpLsb   = 5;
    localparam int unsigned OpndMsb = 4;
    localparam int unsigned OpndLsb = 0;
    localparam int unsigned OpndW   = OpndMsb - OpndLsb + 1;

endpackage

// File: rtl/picomips_if.sv
// Program-memory and stream signals between the core (master) and its environment (slave).
interface picomips_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 5
);
    logic [PC_W-1:0]   instr_addr;
    logic [7:0]        instr_data;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] acc_out;

    modport master (
        output instr_addr, in_ready, out_data, out_valid, acc_out,
        input  instr_data, in_data, in_valid, out_ready
    );

    modport slave (
        input  instr_addr, in_ready, out_data, out_valid, acc_out,
        output instr_data, in_data, in_valid, out_ready
    );
endinterface

// File: rtl/picomips_alu.sv
// Combinational accumulator ALU: fixed-point MULI, ADD/ADDI with optional saturation, RTA pass.
module picomips_alu
    import picomips_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 3,
    parameter int unsigned SAT    = 0
) (
    input  op_t                      i_op,
    input  logic signed [DATA_W-1:0] i_acc,
    input  logic signed [DATA_W-1:0] i_operand,
    output logic signed [DATA_W-1:0] o_result
);
    localparam int unsigned W2 = 2 * DATA_W;
    localparam logic signed [W2-1:0] MaxV = {{(DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [W2-1:0] MinV = {{(DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [DATA_W:0] w_sum;
    logic signed [W2-1:0]   w_prod;
    logic signed [W2-1:0]   w_shifted;

    // Clamp to the DATA_W signed range when saturating, otherwise keep the low bits.
    function automatic logic signed [DATA_W-1:0] fit(input logic signed [W2-1:0] v);
        if (SAT != 0) begin
            if (v > MaxV) return MaxV[DATA_W-1:0];
            if (v < MinV) return MinV[DATA_W-1:0];
        end
        return v[DATA_W-1:0];
    endfunction

    assign w_sum     = {i_acc[DATA_W-1], i_acc} + {i_operand[DATA_W-1], i_operand};
    assign w_prod    = $signed({{DATA_W{i_acc[DATA_W-1]}}, i_acc})
                     * $signed({{DATA_W{i_operand[DATA_W-1]}}, i_operand});
    assign w_shifted = w_prod >>> FRAC_W;

    always_comb begin
        o_result = i_acc;
        case (i_op)
            OpMuli:        o_result = fit(w_shifted);
            OpRta:         o_result = i_operand;
            OpAdd, OpAddi: o_result = fit(W2'(w_sum));
            default:       o_result = i_acc;
        endcase
    end
endmodule

// File: rtl/picomips_core.sv
// Accumulator core: FETCH/EXEC/OUT_WAIT sequencer, pc, acc, register file and stream ports.
module picomips_core
    import picomips_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 2,
    parameter int unsigned PC_W   = 5,
    parameter int unsigned FRAC_W = 3,
    parameter int unsigned SAT    = 0
) (
    input logic        i_clk,
    input logic        i_rst_n,
    picomips_if.master bus
);
    localparam int unsigned RegAw = $clog2(NREGS);

    state_t                   r_state, w_state_next;
    logic [PC_W-1:0]          r_pc, w_pc_next, w_pc_inc;
    logic signed [DATA_W-1:0] r_acc, w_acc_next;
    logic [DATA_W-1:0]        r_regs [NREGS];
    logic [DATA_W-1:0]        r_out_data;
    logic                     r_out_valid;

    op_t                      w_op;
    logic [OpndW-1:0]         w_opnd;
    logic [RegAw-1:0]         w_ra;
    logic signed [DATA_W-1:0] w_imm, w_reg_rd, w_alu_b, w_alu_res;
    logic                     w_reg_we, w_in_ready, w_out_load, w_out_done;

    assign w_op     = op_t'(bus.instr_data[OpMsb:OpLsb]);
    assign w_opnd   = bus.instr_data[OpndMsb:OpndLsb];
    assign w_ra     = bus.instr_data[RegAw-1:0];
    // Sign-extended operand doubled: the low bit is always zero.
    assign w_imm    = {{(DATA_W - OpndW){w_opnd[OpndMsb]}}, w_opnd[OpndMsb-1:0], 1'b0};
    assign w_reg_rd = r_regs[w_ra];
    assign w_alu_b  = (w_op == OpMuli || w_op == OpAddi) ? w_imm : w_reg_rd;
    assign w_pc_inc = r_pc + PC_W'(1);

    picomips_alu #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .SAT    (SAT)
    ) u_alu (
        .i_op      (w_op),
        .i_acc     (r_acc),
        .i_operand (w_alu_b),
        .o_result  (w_alu_res)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_acc_next   = r_acc;
        w_reg_we     = 1'b0;
        w_in_ready   = 1'b0;
        w_out_load   = 1'b0;
        w_out_done   = 1'b0;
        unique case (r_state)
            StFetch: w_state_next = StExec;
            StExec: begin
                w_pc_next    = w_pc_inc;
                w_state_next = StFetch;
                case (w_op)
                    OpJmp: w_pc_next = PC_W'(w_opnd);
                    OpLin: begin
                        w_in_ready = 1'b1;
                        if (bus.in_valid) begin
                            w_acc_next = bus.in_data;
                        end else begin
                            w_pc_next    = r_pc;
                            w_state_next = StExec;
                        end
                    end
                    OpAtr: w_reg_we = 1'b1;
                    OpOut: begin
                        w_out_load   = 1'b1;
                        w_pc_next    = r_pc;
                        w_state_next = StOutWait;
                    end
                    default: w_acc_next = w_alu_res;
                endcase
            end
            StOutWait: begin
                if (bus.out_ready) begin
                    w_out_done   = 1'b1;
                    w_pc_next    = w_pc_inc;
                    w_state_next = StFetch;
                end
            end
            default: w_state_next = StFetch;
        endcase
    end

    // pc doubles as the registered instruction address, so the ROM reads during FETCH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StFetch;
            r_pc        <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_acc   <= w_acc_next;
            if (w_out_load) begin
                r_out_data  <= r_acc;
                r_out_valid <= 1'b1;
            end else if (w_out_done) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_reg_we) begin
            r_regs[w_ra] <= r_acc;
        end
    end

    assign bus.instr_addr = r_pc;
    assign bus.in_ready   = w_in_ready;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.acc_out    = r_acc;
endmodule

// File: tb/tb_picomips_core.sv
// Directed bench: a saturating NREGS=4 core and a wrapping NREGS=2 core run the same programs.
module tb_picomips_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] rom [32];
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    picomips_if #(.DATA_W(8), .PC_W(5)) bus_s ();
    picomips_if #(.DATA_W(8), .PC_W(5)) bus_w ();

    assign bus_s.in_data   = in_data;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.out_ready = out_ready;
    assign bus_w.in_data   = in_data;
    assign bus_w.in_valid  = in_valid;
    assign bus_w.out_ready = out_ready;

    always @(posedge clk) begin
        bus_s.instr_data <= rom[bus_s.instr_addr];
        bus_w.instr_data <= rom[bus_w.instr_addr];
    end

    picomips_core #(
        .DATA_W(8), .NREGS(4), .PC_W(5), .FRAC_W(3), .SAT(1)
    ) u_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_s)
    );

    picomips_core #(
        .DATA_W(8), .NREGS(2), .PC_W(5), .FRAC_W(3), .SAT(0)
    ) u_wrap (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_w)
    );

    typedef struct {
        string          name;
        logic [3:0][7:0] prog;
        logic [7:0]     din;
        logic [7:0]     exp_s;
        logic [7:0]     exp_w;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [7:0] ins(input int op, input int opnd);
        return {op[2:0], opnd[4:0]};
    endfunction

    function automatic vec_t mk(input string n, input logic [7:0] i0, input logic [7:0] i1,
                                input logic [7:0] i2, input logic [7:0] i3,
                                input logic [7:0] din, input logic [7:0] es,
                                input logic [7:0] ew);
        vec_t v;
        v.name  = n;
        v.prog  = {i3, i2, i1, i0};
        v.din   = din;
        v.exp_s = es;
        v.exp_w = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_out(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_s.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: out_valid timeout, got 0, expected 1", name);
        end
    endtask

    task automatic feed(input logic [7:0] v, input string name);
        bit ok;
        ok       = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_s.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: in_ready timeout, got 0, expected 1", name);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        // opcodes: 0 JMP 1 LIN 2 MULI 3 ATR 4 RTA 5 ADD 6 ADDI 7 OUT
        vecs[0] = mk("muli3",     ins(1,0), ins(2,3),  ins(7,0), ins(0,0), 8'd40,  8'h1E, 8'h1E);
        vecs[1] = mk("muli_neg",  ins(1,0), ins(2,30), ins(7,0), ins(0,0), 8'd40,  8'hEC, 8'hEC);
        vecs[2] = mk("addi10",    ins(1,0), ins(6,10), ins(7,0), ins(0,0), 8'd0,   8'h14, 8'h14);
        vecs[3] = mk("addi_ovf",  ins(1,0), ins(6,15), ins(7,0), ins(0,0), 8'd100, 8'h7F, 8'h82);
        vecs[4] = mk("muli_min",  ins(1,0), ins(2,3),  ins(7,0), ins(0,0), 8'h80,  8'hA0, 8'hA0);
        vecs[5] = mk("atr_add",   ins(1,0), ins(3,1),  ins(5,1), ins(7,0), 8'd100, 8'h7F, 8'hC8);
        vecs[6] = mk("addi_neg",  ins(1,0), ins(6,16), ins(7,0), ins(0,0), 8'h90,  8'h80, 8'h70);
        vecs[7] = mk("rta_reset", ins(1,0), ins(4,0),  ins(7,0), ins(0,0), 8'd55,  8'h00, 8'h00);
        vecs[8] = mk("muli_sat",  ins(1,0), ins(2,15), ins(7,0), ins(0,0), 8'd50,  8'h7F, 8'hBB);

        for (int a = 0; a < 32; a++) rom[a] = 8'h00;
        do_reset();
        chk("reset_addr", 32'(bus_s.instr_addr), 32'd0);
        chk("reset_acc", 32'(bus_s.acc_out), 32'd0);
        chk("reset_out_valid", 32'(bus_s.out_valid), 32'd0);
        chk("reset_out_data", 32'(bus_s.out_data), 32'd0);

        for (int k = 0; k < 9; k++) begin
            for (int a = 0; a < 32; a++) rom[a] = (a < 4) ? vecs[k].prog[a[1:0]] : 8'h00;
            in_data   = vecs[k].din;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            do_reset();
            wait_out(vecs[k].name, ok);
            if (ok) begin
                chk({vecs[k].name, "_sat"}, 32'(bus_s.out_data), 32'(vecs[k].exp_s));
                chk({vecs[k].name, "_wrap"}, 32'(bus_w.out_data), 32'(vecs[k].exp_w));
            end
        end

        // Stream twice through LIN; MULI 3; OUT; JMP 0 with stalls on both sides.
        for (int a = 0; a < 32; a++) rom[a] = 8'h00;
        rom[0] = ins(1, 0);
        rom[1] = ins(2, 3);
        rom[2] = ins(7, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("lin_stall_ready", 32'(bus_s.in_ready), 32'd1);
            chk("lin_stall_acc", 32'(bus_s.acc_out), 32'd0);
            chk("lin_stall_pc", 32'(bus_s.instr_addr), 32'd0);
            @(negedge clk);
        end
        in_data  = 8'd40;
        in_valid = 1'b1;
        wait_out("stream1", ok);
        for (int i = 0; i < 5; i++) begin
            chk("out_stall_valid", 32'(bus_s.out_valid), 32'd1);
            chk("out_stall_data", 32'(bus_s.out_data), 32'h1E);
            chk("out_stall_pc", 32'(bus_s.instr_addr), 32'd2);
            chk("out_stall_in_ready", 32'(bus_s.in_ready), 32'd0);
            @(negedge clk);
        end
        chk("stream1_acc", 32'(bus_s.acc_out), 32'h1E);
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_handshake_drop", 32'(bus_s.out_valid), 32'd0);
        wait_out("stream2", ok);
        if (ok) begin
            chk("stream2_sat", 32'(bus_s.out_data), 32'h1E);
            chk("stream2_wrap", 32'(bus_w.out_data), 32'h1E);
        end
        out_ready = 1'b0;

        // Asynchronous reset while parked in OUT_WAIT, then while stalled on LIN.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outwait_valid", 32'(bus_s.out_valid), 32'd0);
        chk("rst_outwait_valid_w", 32'(bus_w.out_valid), 32'd0);
        chk("rst_outwait_addr", 32'(bus_s.instr_addr), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_addr", 32'(bus_s.instr_addr), 32'd0);
        chk("post_rst_lin_ready", 32'(bus_s.in_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_lin_ready", 32'(bus_s.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register file: LIN 7; ATR 3; LIN 5; ADD 3; OUT; RTA 3; OUT; JMP 7.
        for (int a = 0; a < 32; a++) rom[a] = 8'h00;
        rom[0] = ins(1, 0);
        rom[1] = ins(3, 3);
        rom[2] = ins(1, 0);
        rom[3] = ins(5, 3);
        rom[4] = ins(7, 0);
        rom[5] = ins(4, 3);
        rom[6] = ins(7, 0);
        rom[7] = ins(0, 7);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        do_reset();
        feed(8'd7, "reg_feed7");
        feed(8'd5, "reg_feed5");
        wait_out("reg_add", ok);
        if (ok) begin
            chk("reg_add_sat", 32'(bus_s.out_data), 32'd12);
            chk("reg_add_wrap", 32'(bus_w.out_data), 32'd12);
        end
        wait_out("reg_rta", ok);
        if (ok) begin
            chk("reg_rta_sat", 32'(bus_s.out_data), 32'd7);
            chk("reg_rta_wrap", 32'(bus_w.out_data), 32'd7);
        end

        // 32 ADDI 1 instructions: pc walks 0..31 and wraps to 0.
        for (int a = 0; a < 32; a++) rom[a] = ins(6, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("two_cycle_pc", 32'(bus_s.instr_addr), 32'd1);
        chk("two_cycle_acc", 32'(bus_s.acc_out), 32'd2);
        repeat (60) @(posedge clk);
        #1;
        chk("pc_last", 32'(bus_s.instr_addr), 32'd31);
        repeat (2) @(posedge clk);
        #1;
        chk("pc_wrap", 32'(bus_s.instr_addr), 32'd0);
        chk("pc_wrap_acc_sat", 32'(bus_s.acc_out), 32'h40);
        chk("pc_wrap_acc_wrap", 32'(bus_w.acc_out), 32'h40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
